// File: rtl/ubus_arb_pkg.sv
// Shared types and constants for the UBUS arbiter and its picker.
package ubus_arb_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_START,
        ST_ADDR,
        ST_NOP,
        ST_DATA
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width that stays at least one bit for single-entry ranges
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ubus_arb_picker.sv
// Rotate-priority-rotate-back selector: lowest set request at or after ptr wins.
module ubus_arb_picker
    import ubus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = idx_w(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] winner,
    output logic [IDX_W-1:0]       winner_idx
);

    logic [2*NUM_MASTERS-1:0] doubled;
    logic [NUM_MASTERS-1:0]   rotated;
    logic                     found;
    int                       pos;
    int                       sum;

    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[NUM_MASTERS-1:0];
        found   = 1'b0;
        pos     = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                pos   = i;
            end
        end
        sum = pos + int'(ptr);
        if (sum >= NUM_MASTERS) begin
            sum = sum - NUM_MASTERS;
        end
        winner_idx = IDX_W'(sum);
        winner     = '0;
        if (found) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ubus_arbiter.sv
// UBUS arbiter and phase sequencer: grants the bus at each START, sequences
// ADDR/NOP/DATA phases and aborts stalled data phases via a watchdog.
module ubus_arbiter
    import ubus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int RR_MODE     = ARB_FIXED,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                   ubus_clock,
    input  logic                   ubus_reset,
    input  logic [NUM_MASTERS-1:0] ubus_req,
    output logic [NUM_MASTERS-1:0] ubus_gnt,
    output logic                   ubus_start,
    output logic                   ubus_read,
    output logic                   ubus_write,
    input  logic                   ubus_bip,
    input  logic                   ubus_wait,
    input  logic                   ubus_error,
    output logic                   arb_timeout
);

    localparam int IDX_W = idx_w(NUM_MASTERS);
    localparam int CNT_W = idx_w(WDOG_CYCLES);
    localparam logic [CNT_W-1:0] WDOG_LAST =
        CNT_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    arb_state_e             state, state_next;
    logic [NUM_MASTERS-1:0] gnt, gnt_next;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0]       pick_ptr, win_idx;
    logic [NUM_MASTERS-1:0] win;
    logic [CNT_W-1:0]       wdog_cnt, wdog_cnt_next;
    logic                   timeout, timeout_next;
    logic                   data_done, wdog_hit;

    assign pick_ptr = (RR_MODE == ARB_RR) ? rr_ptr : '0;

    ubus_arb_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req        (ubus_req),
        .ptr        (pick_ptr),
        .winner     (win),
        .winner_idx (win_idx)
    );

    assign data_done = ubus_error | (~ubus_bip & ~ubus_wait);
    // Counter holds the number of completed DATA cycles before the current one
    assign wdog_hit  = (WDOG_CYCLES > 0) && (wdog_cnt == WDOG_LAST);

    always_comb begin
        state_next    = state;
        gnt_next      = gnt;
        rr_ptr_next   = rr_ptr;
        wdog_cnt_next = wdog_cnt;
        timeout_next  = 1'b0;
        case (state)
            ST_RESET: state_next = ST_START;
            ST_START: begin
                if (|ubus_req) begin
                    state_next  = ST_ADDR;
                    gnt_next    = win;
                    rr_ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                end else begin
                    state_next = ST_NOP;
                end
            end
            ST_ADDR: begin
                state_next    = ST_DATA;
                wdog_cnt_next = '0;
            end
            ST_NOP: state_next = ST_START;
            ST_DATA: begin
                if (data_done) begin
                    gnt_next   = '0;
                    state_next = ST_START;
                end else if (wdog_hit) begin
                    gnt_next     = '0;
                    state_next   = ST_START;
                    timeout_next = 1'b1;
                end else begin
                    wdog_cnt_next = wdog_cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_RESET;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge ubus_clock or posedge ubus_reset) begin
        if (ubus_reset) begin
            state    <= ST_RESET;
            gnt      <= '0;
            rr_ptr   <= '0;
            wdog_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            rr_ptr   <= rr_ptr_next;
            wdog_cnt <= wdog_cnt_next;
            timeout  <= timeout_next;
        end
    end

    assign ubus_gnt    = gnt;
    assign ubus_start  = (state == ST_START);
    assign arb_timeout = timeout;
    // Outside NOP the granted master owns read/write, so release them
    assign ubus_read   = (state == ST_NOP) ? 1'b0 : 1'bz;
    assign ubus_write  = (state == ST_NOP) ? 1'b0 : 1'bz;

endmodule

// File: doc/ubus_arbiter.md
# ubus_arbiter

Parameterised bus arbiter and phase sequencer for the UBUS application environment. It owns `ubus_start` and walks the bus through its start, address and data phases. At each start phase it grants the bus to one of `NUM_MASTERS` requesters, using either fixed priority or round-robin. If nobody requests, it drives a no-op address phase. A watchdog forcibly ends data phases that stall.

## Interface

Parameters:
- `NUM_MASTERS`, 2: number of requesting masters, 1..8.
- `RR_MODE`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `WDOG_CYCLES`, 64: maximum data-phase length in cycles before forced abort; 0 disables the watchdog.

Ports:
- `ubus_clock` in 1: bus clock; all logic on its rising edge.
- `ubus_reset` in 1: reset, asynchronous, active-high.
- `ubus_req` in `NUM_MASTERS`: per-master bus request, level.
- `ubus_gnt` out `NUM_MASTERS`: one-hot grant; all zero when no master owns the bus.
- `ubus_start` out 1: start-phase marker, high for exactly one cycle per transfer slot.
- `ubus_read` out 1: driven 0 during no-op address phases, Z otherwise.
- `ubus_write` out 1: driven 0 during no-op address phases, Z otherwise.
- `ubus_bip` in 1: burst in progress, from the slave side.
- `ubus_wait` in 1: slave wait.
- `ubus_error` in 1: slave error; ends the transfer.
- `arb_timeout` out 1: one-cycle pulse when the watchdog aborts a data phase.

## Operation

- States: RESET, START, ADDR, NOP, DATA.
- RESET (held while `ubus_reset`=1):
  - `ubus_start`=0, `ubus_gnt`=0, `ubus_read`/`ubus_write`=Z, `arb_timeout`=0.
  - Round-robin pointer = 0; watchdog counter = 0.
- RESET → START on the first clock edge after reset deasserts. `ubus_start` becomes 1 in that cycle.
- START (`ubus_start`=1, `ubus_gnt`=0): at the closing edge, sample `ubus_req`.
  - Any request: load the winner into `ubus_gnt`, go to ADDR.
  - No request: go to NOP.
- ADDR: one cycle. Grant held; `ubus_read`/`ubus_write`=Z, because the owner drives them. → DATA.
- NOP: one cycle. `ubus_read`=0, `ubus_write`=0, `ubus_gnt`=0. → START.
- DATA: grant held. At each edge, evaluate the exit condition `ubus_error` OR (`ubus_bip`=0 AND `ubus_wait`=0).
  - True: clear `ubus_gnt`, go to START.
  - False: stay in DATA.
- Watchdog:
  - Counter clears on ADDR→DATA and increments every DATA cycle.
  - When it reaches `WDOG_CYCLES` with the exit condition still false: pulse `arb_timeout`, clear grant, go to START.
  - Error and normal exit take precedence over the watchdog in the same cycle; no pulse is generated then.
- Fixed priority: the lowest set index of `ubus_req` wins.
- Round-robin:
  - Search starts at the pointer and wraps from index `NUM_MASTERS`-1 to 0.
  - On grant, pointer = winner+1 mod `NUM_MASTERS`.
  - Pointer is unchanged on NOP.
- Requests are sampled only at the START closing edge. Drops or raises at any other time have no effect until the next START.
- `ubus_req` bits at or above `NUM_MASTERS` do not exist; the width equals `NUM_MASTERS` exactly.

## Timing

- Every output is registered; there are no combinational input-to-output paths.
- Transfer slot: 1 START + 1 ADDR + N DATA cycles, with N ≥ 1.
- Idle slot: START + NOP = 2 cycles.
- The grant is visible from the first ADDR cycle through the last DATA cycle. It is zero in START and NOP.
- Cycle after the final DATA cycle is START: back-to-back transfers have no extra gap.
- Reset asserted mid-transfer immediately forces the RESET output values, including grant cleared and read/write released to Z. The pointer returns to 0.
- `arb_timeout` is high for exactly the first START cycle after an abort.

## Structure

- Package `ubus_arb_pkg` holds:
  - the state enum (`ST_RESET`, `ST_START`, `ST_ADDR`, `ST_NOP`, `ST_DATA`);
  - mode constants `ARB_FIXED`=0 and `ARB_RR`=1.
- Sub-module `ubus_arb_picker`: combinational rotate-priority-rotate-back one-hot selector. Inputs: requests and pointer. Outputs: one-hot winner and winner index. Fixed mode ties the pointer to 0.

## Test plan

- Reset release, no requests → START/NOP alternate every cycle; `ubus_read`=`ubus_write`=0 in each NOP, Z otherwise; `ubus_gnt`=0 throughout.
- Fixed mode, `ubus_req`=2'b11, each transfer 1 DATA cycle (bip=0, wait=0) → every grant is 2'b01; master 1 starves.
- RR mode, `NUM_MASTERS`=4, `ubus_req`=4'b1111 → grants cycle 0001, 0010, 0100, 1000, 0001; slot length 3 cycles.
- RR mode, `ubus_req`=4'b1001, pointer at 1 → grant 1000 then 0001; wrap-around verified.
- Data phase with wait=1 for 3 cycles then bip=0/wait=0 → grant held 5 cycles (ADDR + 4 DATA); `ubus_error`=1 on the 2nd DATA cycle → immediate START next cycle.
- `WDOG_CYCLES`=4, wait stuck at 1 → abort after 4 DATA cycles, one-cycle `arb_timeout`, grant cleared.
- Reset asserted during DATA → all outputs return to reset values asynchronously.
